// File: rtl/i2c_write_seq.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_write_seq
//  Description : Sequences one I2C multi-byte write per software request.
//                Sits between the CSR/FIFO send buffer and the i2c_master
//                AXI-stream command and data channels. It issues one command
//                beat, then streams exactly len bytes from the FIFO with tlast
//                on the final byte. It then waits for the bus to go idle and
//                reports completion with a one-cycle done pulse and a sticky
//                status word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LenWidth       width of the byte-count request (max 2**LenWidth-1 bytes)
//    TimeoutCycles  cycles allowed in WAIT_IDLE before a timeout error (>=1)
//  Ports
//    clk                 system clock
//    reset               asynchronous, active-low reset
//    start               one-cycle request pulse
//    addr / len          slave address / byte count, sampled on accepted start
//    fifo_data           head of send FIFO
//    fifo_have_next      send FIFO non-empty
//    fifo_next           pop FIFO head (one cycle per transferred byte)
//    cmd_*               i2c_master command channel
//    data_*              i2c_master data channel
//    bus_busy            i2c_master busy
//    missed_ack          i2c_master missed-ack pulse
//    busy                transfer in progress
//    done                one-cycle completion pulse (success or error)
//    status              sticky {timeout, nack, overrun}; cleared on accepted start
// ============================================================================
module i2c_write_seq #(
  parameter int LenWidth      = 8,
  parameter int TimeoutCycles = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [6:0]          addr,
  input  logic [LenWidth-1:0] len,
  input  logic [7:0]          fifo_data,
  input  logic                fifo_have_next,
  output logic                fifo_next,
  output logic [6:0]          cmd_address,
  output logic                cmd_write_multiple,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [7:0]          data_tdata,
  output logic                data_tvalid,
  output logic                data_tlast,
  input  logic                data_tready,
  input  logic                bus_busy,
  input  logic                missed_ack,
  output logic                busy,
  output logic                done,
  output logic [2:0]          status
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CMD       = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // Status bit positions
  localparam int STAT_OVERRUN = 0;
  localparam int STAT_NACK    = 1;
  localparam int STAT_TIMEOUT = 2;

  localparam int                    TimerWidth = $clog2(TimeoutCycles + 1);
  localparam logic [TimerWidth-1:0] TimerMax   = TimerWidth'(TimeoutCycles);
  localparam logic [TimerWidth-1:0] TimerOne   = TimerWidth'(1);
  localparam logic [LenWidth-1:0]   LenOne     = LenWidth'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]            state_q,     state_d;
  logic [6:0]            addr_q,      addr_d;
  logic [LenWidth-1:0]   len_q,       len_d;
  logic [LenWidth-1:0]   remaining_q, remaining_d;
  logic [TimerWidth-1:0] timer_q,     timer_d;
  logic [2:0]            status_q,    status_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic                  in_cmd;
  logic                  in_data;
  logic                  data_beat;
  logic [TimerWidth-1:0] timer_inc;

  assign in_cmd    = (state_q == ST_CMD);
  assign in_data   = (state_q == ST_DATA);
  assign timer_inc = timer_q + TimerOne;

  // A missed ack aborts the stream in the same cycle. tvalid is withdrawn
  // so that no byte is popped from the FIFO after the slave has refused.
  assign data_tvalid = in_data & fifo_have_next & ~missed_ack;
  assign data_beat   = data_tvalid & data_tready;
  assign fifo_next   = data_beat;

  // Outputs are gated by state so they all read 0 whenever the block is idle
  // or held in reset.
  assign cmd_valid          = in_cmd;
  assign cmd_write_multiple = in_cmd;
  assign cmd_address        = in_cmd  ? addr_q    : 7'd0;
  assign data_tdata         = in_data ? fifo_data : 8'd0;
  assign data_tlast         = in_data & (remaining_q == LenOne);

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign status = status_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    status_d    = status_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          status_d = 3'b000;
          if (len != '0) begin
            addr_d  = addr;
            len_d   = len;
            state_d = ST_CMD;
          end else begin
            // Zero-length request completes without touching the bus.
            state_d = ST_DONE;
          end
        end
      end

      ST_CMD: begin
        // cmd_valid is held with a stable address until the handshake.
        if (cmd_ready) begin
          remaining_d = len_q;
          state_d     = ST_DATA;
        end
      end

      ST_DATA: begin
        if (missed_ack) begin
          status_d[STAT_NACK] = 1'b1;
          state_d             = ST_WAIT_IDLE;
        end else if (data_beat) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LenOne;
          end
          if (remaining_q <= LenOne) begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        timer_d = timer_inc;
        if (missed_ack) begin
          status_d[STAT_NACK] = 1'b1;
        end
        // The first WAIT_IDLE cycle is skipped for the idle test because the
        // master may not yet have raised busy for the final byte.
        if (!bus_busy && (timer_q != '0)) begin
          state_d = ST_DONE;
        end else if (timer_inc == TimerMax) begin
          status_d[STAT_TIMEOUT] = 1'b1;
          state_d                = ST_DONE;
        end
      end

      ST_DONE: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request arriving while a transfer is in flight, including the DONE
    // cycle, is dropped. This is recorded so that software can detect it.
    if (start && (state_q != ST_IDLE)) begin
      status_d[STAT_OVERRUN] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 7'd0;
      len_q       <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      status_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      status_q    <= status_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_write_seq
//  Description : Scoreboard testbench for i2c_write_seq. Stimulus pushes the
//                expected command, data and completion records. A monitor pops
//                them and compares each one when the DUT presents a handshake
//                or a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_write_seq;

  localparam int LW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [6:0]    addr;
  logic [LW-1:0] len;
  logic [7:0]    fifo_data;
  logic          fifo_have_next;
  logic          fifo_next;
  logic [6:0]    cmd_address;
  logic          cmd_write_multiple;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    data_tdata;
  logic          data_tvalid;
  logic          data_tlast;
  logic          data_tready;
  logic          bus_busy;
  logic          missed_ack;
  logic          busy;
  logic          done;
  logic [2:0]    status;

  always #5 clk = ~clk;

  i2c_write_seq #(.LenWidth(LW), .TimeoutCycles(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .addr               (addr),
    .len                (len),
    .fifo_data          (fifo_data),
    .fifo_have_next     (fifo_have_next),
    .fifo_next          (fifo_next),
    .cmd_address        (cmd_address),
    .cmd_write_multiple (cmd_write_multiple),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .data_tdata         (data_tdata),
    .data_tvalid        (data_tvalid),
    .data_tlast         (data_tlast),
    .data_tready        (data_tready),
    .bus_busy           (bus_busy),
    .missed_ack         (missed_ack),
    .busy               (busy),
    .done               (done),
    .status             (status)
  );

  // --------------------------------------------------------------------------
  // Send FIFO model
  // --------------------------------------------------------------------------
  logic [7:0] fmem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_flush;

  assign fifo_have_next = (wr_ptr != rd_ptr);
  assign fifo_data      = fmem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_flush)     rd_ptr <= wr_ptr;
    else if (fifo_next) rd_ptr <= rd_ptr + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [6:0] exp_cmd [$];
  logic [8:0] exp_dat [$];
  logic [2:0] exp_st  [$];

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int last_beat_cyc = 0;
  int done_cyc      = 0;

  logic [6:0] m_cmd;
  logic [8:0] m_dat;
  logic [2:0] m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event occurred with no expectation pending (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
      else begin
        m_cmd = exp_cmd.pop_front();
        chk("cmd_beat{wm,addr}", {24'd0, cmd_write_multiple, cmd_address}, {24'd0, 1'b1, m_cmd});
      end
    end
    if (data_tvalid && data_tready) begin
      last_beat_cyc = cyc;
      if (exp_dat.size() == 0) fail_now("unexpected_data");
      else begin
        m_dat = exp_dat.pop_front();
        chk("data_beat{pop,last,data}", {22'd0, fifo_next, data_tlast, data_tdata},
            {22'd0, 1'b1, m_dat});
      end
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
      if (exp_st.size() == 0) fail_now("unexpected_done");
      else begin
        m_st = exp_st.pop_front();
        chk("done_status", {29'd0, status}, {29'd0, m_st});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fmem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic flush();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
  endtask

  task automatic issue(input logic [6:0] a, input logic [LW-1:0] l);
    addr  = a;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 200) begin
      tick();
      n++;
    end
    if (done_seen < target) begin
      checks++;
      failures++;
      $display("FAIL done_wait: done_count actual=%0d required=%0d", done_seen, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    int tv;
    int pops;
    for (int i = 0; i < 16; i++) fmem[i] = 8'h00;
    reset = 1'b0; start = 1'b0; addr = 7'd0; len = '0;
    cmd_ready = 1'b0; data_tready = 1'b0; bus_busy = 1'b0; missed_ack = 1'b0;
    fifo_flush = 1'b0;
    #3;
    chk("reset_outputs",
        {7'd0, busy, done, cmd_valid, cmd_write_multiple, data_tvalid, data_tlast,
         fifo_next, status, cmd_address, data_tdata}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // 1: basic three-byte write
    cmd_ready = 1'b1; data_tready = 1'b1; bus_busy = 1'b0;
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
    exp_cmd.push_back(7'h27);
    exp_dat.push_back({1'b0, 8'h11});
    exp_dat.push_back({1'b0, 8'h22});
    exp_dat.push_back({1'b1, 8'h33});
    exp_st.push_back(3'b000);
    issue(7'h27, 8'd3);
    chk("start_to_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    wait_done(1);
    chk("t1_fifo_left", wr_ptr - rd_ptr, 32'd0);
    chk("t1_last_to_done_ge2", {31'd0, (done_cyc - last_beat_cyc) >= 2}, 32'd1);

    // 2: empty FIFO stalls the stream without error
    tick();
    exp_cmd.push_back(7'h50);
    exp_dat.push_back({1'b0, 8'hA1});
    exp_dat.push_back({1'b1, 8'hA2});
    exp_st.push_back(3'b000);
    issue(7'h50, 8'd2);
    tv = 0; pops = 0;
    repeat (10) begin
      tick();
      if (data_tvalid) tv++;
      if (fifo_next)   pops++;
    end
    chk("t2_stall_tvalid_cycles", tv, 32'd0);
    chk("t2_stall_pops", pops, 32'd0);
    chk("t2_stall_busy_status", {28'd0, busy, status}, {28'd0, 1'b1, 3'b000});
    push_fifo(8'hA1); push_fifo(8'hA2);
    wait_done(2);

    // 3: missed ack after the first of four bytes
    tick();
    data_tready = 1'b0;
    push_fifo(8'hB1); push_fifo(8'hB2); push_fifo(8'hB3); push_fifo(8'hB4);
    exp_cmd.push_back(7'h3C);
    exp_dat.push_back({1'b0, 8'hB1});
    exp_st.push_back(3'b010);
    issue(7'h3C, 8'd4);
    tick();
    chk("t3_tvalid_pending", {31'd0, data_tvalid}, 32'd1);
    data_tready = 1'b1;
    tick();
    data_tready = 1'b0; missed_ack = 1'b1; bus_busy = 1'b1;
    #1;
    chk("t3_tvalid_dropped_on_nack", {31'd0, data_tvalid}, 32'd0);
    tick();
    missed_ack = 1'b0;
    repeat (4) tick();
    chk("t3_no_done_while_bus_busy", done_seen, 32'd2);
    bus_busy = 1'b0;
    wait_done(3);
    chk("t3_fifo_left", wr_ptr - rd_ptr, 32'd3);

    // 4: bus stuck busy -> timeout
    tick();
    flush();
    data_tready = 1'b1; bus_busy = 1'b1;
    push_fifo(8'hC1);
    exp_cmd.push_back(7'h11);
    exp_dat.push_back({1'b1, 8'hC1});
    exp_st.push_back(3'b100);
    issue(7'h11, 8'd1);
    wait_done(4);
    // beat cycle + 1 enters WAIT_IDLE; done follows 16 cycles later
    chk("t4_timeout_latency", done_cyc - last_beat_cyc, 32'd17);
    bus_busy = 1'b0;

    // 5: start while busy -> overrun, original transfer unaffected
    tick();
    flush();
    data_tready = 1'b0;
    push_fifo(8'hE1); push_fifo(8'hE2); push_fifo(8'hE3);
    exp_cmd.push_back(7'h42);
    exp_dat.push_back({1'b0, 8'hE1});
    exp_dat.push_back({1'b0, 8'hE2});
    exp_dat.push_back({1'b1, 8'hE3});
    exp_st.push_back(3'b001);
    issue(7'h42, 8'd3);
    tick();
    issue(7'h13, 8'd5);
    chk("t5_overrun_flag", {28'd0, busy, status}, {28'd0, 1'b1, 3'b001});
    data_tready = 1'b1;
    wait_done(5);

    // 5b: zero-length request -> done next cycle, no command
    tick();
    exp_st.push_back(3'b000);
    issue(7'h13, 8'd0);
    chk("t5_len0_{done,cmd_valid}", {30'd0, done, cmd_valid}, 32'd2);
    wait_done(6);

    // 6: asynchronous reset mid-DATA, then a clean restart
    tick();
    flush();
    data_tready = 1'b0;
    push_fifo(8'hD1); push_fifo(8'hD2); push_fifo(8'hD3);
    exp_cmd.push_back(7'h55);
    issue(7'h55, 8'd3);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("t6_async_reset_outputs",
        {7'd0, busy, done, cmd_valid, cmd_write_multiple, data_tvalid, data_tlast,
         fifo_next, status, cmd_address, data_tdata}, 32'd0);
    chk("t6_fifo_untouched", wr_ptr - rd_ptr, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    data_tready = 1'b1;
    exp_cmd.push_back(7'h66);
    exp_dat.push_back({1'b0, 8'hD1});
    exp_dat.push_back({1'b0, 8'hD2});
    exp_dat.push_back({1'b1, 8'hD3});
    exp_st.push_back(3'b000);
    issue(7'h66, 8'd3);
    wait_done(7);
    repeat (3) tick();

    chk("scoreboard_drained", exp_cmd.size() + exp_dat.size() + exp_st.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
